// File: rtl/cordic_sincos_mc.sv
// Iterative multi-channel CORDIC sine/cosine engine. One shared rotation datapath
// walks CH phase-offset channels per command and publishes all results together.
module cordic_sincos_mc #(
    parameter int W    = 20,
    parameter int ITER = 18,
    parameter int CH   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    theta,
    output logic            ready,
    output logic            done,
    output logic [CH*W-1:0] sin_out,
    output logic [CH*W-1:0] cos_out
);
    localparam int DW = W + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROT, S_STORE, S_FIN} state_t;

    // atan(2^-i) as a fraction of a full turn, scaled to 2^32.
    function automatic logic [31:0] atan_master(input int idx);
        logic [31:0] v;
        case (idx)
            0:  v = 32'h2000_0000;
            1:  v = 32'h12E4_051E;
            2:  v = 32'h09FB_385B;
            3:  v = 32'h0511_11D4;
            4:  v = 32'h028B_0D43;
            5:  v = 32'h0145_D7E1;
            6:  v = 32'h00A2_F61E;
            7:  v = 32'h0051_7C55;
            8:  v = 32'h0028_BE53;
            9:  v = 32'h0014_5F2F;
            10: v = 32'h000A_2F98;
            11: v = 32'h0005_17CC;
            12: v = 32'h0002_8BE6;
            13: v = 32'h0001_45F3;
            14: v = 32'h0000_A2FA;
            15: v = 32'h0000_517D;
            16: v = 32'h0000_28BE;
            17: v = 32'h0000_145F;
            18: v = 32'h0000_0A30;
            19: v = 32'h0000_0518;
            20: v = 32'h0000_028C;
            21: v = 32'h0000_0146;
            22: v = 32'h0000_00A3;
            23: v = 32'h0000_0051;
            24: v = 32'h0000_0029;
            25: v = 32'h0000_0014;
            26: v = 32'h0000_000A;
            27: v = 32'h0000_0005;
            28: v = 32'h0000_0003;
            29: v = 32'h0000_0001;
            30: v = 32'h0000_0001;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic signed [DW-1:0] atan_entry(input int idx);
        logic [63:0] v;
        v = {32'h0, atan_master(idx)};
        if (W < 32) v = (v + (64'd1 << (32 - W - 1))) >> (32 - W);
        return $signed(v[DW-1:0]);
    endfunction

    function automatic logic [W-1:0] chan_offset(input int k);
        logic [63:0] num;
        num = (64'(k) << (W + 1)) + 64'(CH);
        return W'(num / (64'(CH) * 64'd2));
    endfunction

    // CORDIC gain compensation 0.6072529350 in Q32, rescaled to full scale 2^(W-2).
    localparam logic [63:0] GAIN_Q32 = 64'd2608131496;
    localparam logic signed [DW-1:0] X0 =
        $signed(DW'((GAIN_Q32 + (64'd1 << (33 - W))) >> (34 - W)));
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic signed [DW-1:0] atan_tbl [32];
    logic [W-1:0]         off_tbl  [8];

    for (genvar g = 0; g < 32; g++) begin : g_atan
        assign atan_tbl[g] = atan_entry(g);
    end
    for (genvar g = 0; g < 8; g++) begin : g_off
        assign off_tbl[g] = chan_offset(g);
    end

    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [4:0]           i_q, i_d;
    logic [W-1:0]         theta_q, theta_d;
    logic                 neg_q, neg_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CH*W-1:0]      sin_sh_q, sin_sh_d, cos_sh_q, cos_sh_d;
    logic [CH*W-1:0]      sin_q, sin_d, cos_q, cos_d;
    logic                 done_q, done_d, ready_q, ready_d;

    logic [W-1:0]         phi, z0;
    logic                 quad_neg;
    logic signed [DW-1:0] x_sh, y_sh;
    logic signed [W-1:0]  cos_res, sin_res;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        theta_d  = theta_q;
        neg_d    = neg_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        sin_sh_d = sin_sh_q;
        cos_sh_d = cos_sh_q;
        sin_d    = sin_q;
        cos_d    = cos_q;

        // Second and third quadrants are folded by a half-turn and the result negated.
        phi      = theta_q + off_tbl[k_q];
        quad_neg = phi[W-1] ^ phi[W-2];
        z0       = quad_neg ? (phi - HALF) : phi;

        x_sh     = x_q >>> i_q;
        y_sh     = y_q >>> i_q;
        cos_res  = x_q[W-1:0];
        sin_res  = y_q[W-1:0];
        if (neg_q) begin
            cos_res = -cos_res;
            sin_res = -sin_res;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    theta_d = theta;
                    k_d     = 3'd0;
                    i_d     = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                neg_d   = quad_neg;
                x_d     = X0;
                y_d     = '0;
                z_d     = {{2{z0[W-1]}}, z0};
                i_d     = 5'd0;
                state_d = S_ROT;
            end
            S_ROT: begin
                if (!z_q[DW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_tbl[i_q];
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_tbl[i_q];
                end
                i_d = i_q + 5'd1;
                if (i_q == 5'(ITER - 1)) state_d = S_STORE;
            end
            S_STORE: begin
                sin_sh_d[k_q*W +: W] = sin_res;
                cos_sh_d[k_q*W +: W] = cos_res;
                // Outputs load together with the last shadow so they appear alongside done.
                if (k_q == 3'(CH - 1)) begin
                    sin_d   = sin_sh_d;
                    cos_d   = cos_sh_d;
                    state_d = S_FIN;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d  = (state_d == S_FIN);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            i_q      <= '0;
            theta_q  <= '0;
            neg_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            sin_sh_q <= '0;
            cos_sh_q <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            theta_q  <= theta_d;
            neg_q    <= neg_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            sin_sh_q <= sin_sh_d;
            cos_sh_q <= cos_sh_d;
            sin_q    <= sin_d;
            cos_q    <= cos_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign sin_out = sin_q;
    assign cos_out = cos_q;

endmodule

// File: tb/tb_cordic_sincos_mc.sv
// Scoreboard bench for cordic_sincos_mc: expected sin/cos come from ideal
// trigonometry of the commanded phase, checked when done is presented.
`timescale 1ns/1ps
module tb_cordic_sincos_mc;
    localparam int  W    = 20;
    localparam int  ITER = 18;
    localparam int  CH   = 3;
    localparam int  N    = CH * (ITER + 2) + 1;
    localparam real PI   = 3.14159265358979323846;
    localparam real TOL_DIR = 8.0;
    // Fixed-point rotation without guard bits drifts a few LSB; random phases get extra slack.
    localparam real TOL_RND = 12.0;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    theta = '0;
    logic            ready, done;
    logic [CH*W-1:0] sin_out, cos_out;

    cordic_sincos_mc #(.W(W), .ITER(ITER), .CH(CH)) dut (
        .clk(clk), .rst(rst), .start(start), .theta(theta),
        .ready(ready), .done(done), .sin_out(sin_out), .cos_out(cos_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  errors = 0;
    int  exp_cyc_q[$];
    real exp_sin_q[$];
    real exp_cos_q[$];
    real tol_q[$];
    logic [CH*W-1:0] last_sin = '0;
    logic [CH*W-1:0] last_cos = '0;

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input real exp, input real tol);
        real diff;
        checks++;
        diff = real'(act) - exp;
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0.2f (+/- %0.0f)", name, act, exp, tol);
        end
    endtask

    task automatic chk_bits(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic real ideal(input logic [W-1:0] th, input int k, input bit want_sin);
        real ang;
        ang = 2.0 * PI * (real'(th) / (2.0 ** W) + real'(k) / real'(CH));
        return (want_sin ? $sin(ang) : $cos(ang)) * (2.0 ** (W - 2));
    endfunction

    task automatic flush();
        exp_cyc_q.delete();
        exp_sin_q.delete();
        exp_cos_q.delete();
        tol_q.delete();
    endtask

    // Called just after a rising edge; the next edge samples the command.
    task automatic issue(input logic [W-1:0] th, input real tol, output int s);
        chk_int("ready_before_start", int'(ready), 1);
        start = 1'b1;
        theta = th;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        theta = W'($urandom);
        exp_cyc_q.push_back(s + N - 1);
        tol_q.push_back(tol);
        for (int k = 0; k < CH; k++) begin
            exp_sin_q.push_back(ideal(th, k, 1'b1));
            exp_cos_q.push_back(ideal(th, k, 1'b0));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_cyc_q.size() == 0 && ready === 1'b1) && n < 4 * N) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4 * N) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d ready=%b after %0d cycles", exp_cyc_q.size(), ready, n);
            flush();
        end
    endtask

    int  mon_ec;
    real mon_tol;
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at tb cycle %0d with nothing pending", cyc);
            end else begin
                mon_ec  = exp_cyc_q.pop_front();
                mon_tol = tol_q.pop_front();
                chk_int("done_cycle", cyc, mon_ec);
                for (int k = 0; k < CH; k++) begin
                    chk_near($sformatf("sin_ch%0d", k), int'($signed(sin_out[k*W +: W])),
                             exp_sin_q.pop_front(), mon_tol);
                    chk_near($sformatf("cos_ch%0d", k), int'($signed(cos_out[k*W +: W])),
                             exp_cos_q.pop_front(), mon_tol);
                end
                last_sin = sin_out;
                last_cos = cos_out;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    int s, s2;
    logic [W-1:0] dir_th [5];

    initial begin
        dir_th[0] = 20'h00000;
        dir_th[1] = 20'h40000;
        dir_th[2] = 20'h80000;
        dir_th[3] = 20'hC0000;
        dir_th[4] = 20'hFFFFF;

        // Reset asserted between edges must act without a clock edge.
        #1;
        rst = 1'b1;
        #1;
        chk_int("rst_ready", int'(ready), 1);
        chk_int("rst_done", int'(done), 0);
        chk_bits("rst_sin", sin_out, '0);
        chk_bits("rst_cos", cos_out, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed phases: zero, quadrant boundaries, wrap-around.
        foreach (dir_th[j]) begin
            issue(dir_th[j], TOL_DIR, s);
            wait_idle();
        end

        // Starts during a busy run are ignored; the next is accepted in cycle N+1.
        issue(20'h2468A, TOL_DIR, s);
        repeat (4) @(posedge clk);
        #1;
        chk_int("busy_ready_c5", int'(ready), 0);
        chk_bits("hold_sin_c5", sin_out, last_sin);
        chk_bits("hold_cos_c5", cos_out, last_cos);
        start = 1'b1;
        theta = 20'h9ABCD;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk_int("busy_ready_c40", int'(ready), 0);
        start = 1'b1;
        theta = 20'h13131;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_int("busy_ready_cN", int'(ready), 0);
        @(posedge clk);
        #1;
        issue(20'h0F0F0, TOL_DIR, s2);
        chk_int("b2b_accept_distance", s2 - s, N + 1);
        wait_idle();

        // Randomized back-to-back commands at full throughput.
        for (int r = 0; r < 8; r++) begin
            issue(W'($urandom), TOL_RND, s);
            repeat (N) @(posedge clk);
            #1;
        end
        wait_idle();

        // Reset in the middle of a run clears everything immediately.
        issue(20'h13579, TOL_DIR, s);
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        flush();
        chk_int("midrst_ready", int'(ready), 1);
        chk_int("midrst_done", int'(done), 0);
        chk_bits("midrst_sin", sin_out, '0);
        chk_bits("midrst_cos", cos_out, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(20'h40000, TOL_DIR, s);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
